// File: rtl/addsub_arb_pkg.sv
// Shared definitions for the AddSub4 arbiter: FSM encoding, widths and helpers.
package addsub_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 4;
    localparam int SETTLE_MAX = 8;
    localparam int STAT_W     = 8;

    // Settle counter runs 0..SETTLE-1, so log2(SETTLE_MAX) bits suffice.
    localparam int CNT_W      = $clog2(SETTLE_MAX);

    // Saturating increment for the grant statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/AddSub4.sv
// 4-bit adder/subtractor: sel=0 -> a+b, sel=1 -> a-b (cout=1 means no borrow).
module AddSub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sel,
    output logic       cout,
    output logic [3:0] sum
);

    logic [4:0] w_full;

    // Subtract as a + ~b + 1 so a single carry chain serves both operations.
    assign w_full = {1'b0, a} + {1'b0, b ^ {4{sel}}} + {4'b0000, sel};
    assign cout   = w_full[4];
    assign sum    = w_full[3:0];

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one AddSub4 between two requesters.
// Optional build macro ADDSUB_ARB_STATS_EN adds per-requester grant counters
// (stat_cnt0/stat_cnt1, saturating at 255).
module addsub_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_sub,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_sub,
    output logic              req1_ready,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_ovf,
`ifdef ADDSUB_ARB_STATS_EN
    output logic [STAT_W-1:0] stat_cnt0,
    output logic [STAT_W-1:0] stat_cnt1,
`endif
    input  logic              rsp_ready
);

    state_t            r_state;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_sub;
    logic              r_id;

    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_sum;
    logic              r_rsp_cout;
    logic              r_rsp_ovf;

    logic              w_gnt0;
    logic              w_gnt1;
    logic [DATA_W-1:0] w_sum;
    logic              w_cout;
    logic              w_ovf;

    // Grant only in IDLE; on a tie, serve whoever was not granted last.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                w_gnt0 = r_last_grant;
                w_gnt1 = !r_last_grant;
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Operand registers are cleared outside an operation, so the adder sees 0 in IDLE.
    AddSub4 u_addsub (r_a, r_b, r_sub, w_cout, w_sum);

    // Signed overflow: result sign differs from a when the effective operands share a sign.
    always_comb begin
        w_ovf = 1'b0;
        if (r_sub) begin
            w_ovf = (r_a[DATA_W-1] != r_b[DATA_W-1]) && (w_sum[DATA_W-1] != r_a[DATA_W-1]);
        end else begin
            w_ovf = (r_a[DATA_W-1] == r_b[DATA_W-1]) && (w_sum[DATA_W-1] != r_a[DATA_W-1]);
        end
    end

    // Sequencer FSM: accept, settle for SETTLE cycles, present the result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_sub        <= 1'b0;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_sum    <= '0;
            r_rsp_cout   <= 1'b0;
            r_rsp_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_a          <= w_gnt1 ? req1_a   : req0_a;
                        r_b          <= w_gnt1 ? req1_b   : req0_b;
                        r_sub        <= w_gnt1 ? req1_sub : req0_sub;
                        r_id         <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        r_cnt        <= '0;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == CNT_W'(SETTLE - 1)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_sum   <= w_sum;
                        r_rsp_cout  <= w_cout;
                        r_rsp_ovf   <= w_ovf;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_a         <= '0;
                        r_b         <= '0;
                        r_sub       <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;
    assign rsp_ovf   = r_rsp_ovf;

`ifdef ADDSUB_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat0;
    logic [STAT_W-1:0] r_stat1;

    // Count grants per requester on the accept cycle, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat0 <= '0;
            r_stat1 <= '0;
        end else begin
            if (w_gnt0) r_stat0 <= sat_inc(r_stat0);
            if (w_gnt1) r_stat1 <= sat_inc(r_stat1);
        end
    end

    assign stat_cnt0 = r_stat0;
    assign stat_cnt1 = r_stat1;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed, table-driven bench for addsub_arbiter (SETTLE=1 and SETTLE=4 instances).
// Honours ADDSUB_ARB_STATS_EN when defined.
module tb_addsub_arbiter;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- SETTLE = 1 instance ----
    logic       rst;
    logic       req0_valid, req0_sub, req0_ready;
    logic [3:0] req0_a, req0_b;
    logic       req1_valid, req1_sub, req1_ready;
    logic [3:0] req1_a, req1_b;
    logic       rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_ready;
    logic [3:0] rsp_sum;
`ifdef ADDSUB_ARB_STATS_EN
    logic [7:0] stat_cnt0, stat_cnt1;
`endif

    addsub_arbiter #(.DATA_W(4), .SETTLE(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sub(req0_sub), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sub(req1_sub), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
`ifdef ADDSUB_ARB_STATS_EN
        .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1),
`endif
        .rsp_ready(rsp_ready)
    );

    // ---- SETTLE = 4 instance ----
    logic       rst_4;
    logic       req0_valid_4, req0_sub_4, req0_ready_4;
    logic [3:0] req0_a_4, req0_b_4;
    logic       req1_valid_4, req1_sub_4, req1_ready_4;
    logic [3:0] req1_a_4, req1_b_4;
    logic       rsp_valid_4, rsp_id_4, rsp_cout_4, rsp_ovf_4, rsp_ready_4;
    logic [3:0] rsp_sum_4;
`ifdef ADDSUB_ARB_STATS_EN
    logic [7:0] stat_cnt0_4, stat_cnt1_4;
`endif

    addsub_arbiter #(.DATA_W(4), .SETTLE(4)) dut4 (
        .clk(clk), .rst(rst_4),
        .req0_valid(req0_valid_4), .req0_a(req0_a_4), .req0_b(req0_b_4),
        .req0_sub(req0_sub_4), .req0_ready(req0_ready_4),
        .req1_valid(req1_valid_4), .req1_a(req1_a_4), .req1_b(req1_b_4),
        .req1_sub(req1_sub_4), .req1_ready(req1_ready_4),
        .rsp_valid(rsp_valid_4), .rsp_id(rsp_id_4), .rsp_sum(rsp_sum_4),
        .rsp_cout(rsp_cout_4), .rsp_ovf(rsp_ovf_4),
`ifdef ADDSUB_ARB_STATS_EN
        .stat_cnt0(stat_cnt0_4), .stat_cnt1(stat_cnt1_4),
`endif
        .rsp_ready(rsp_ready_4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       id;
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];

    // One complete operation on the SETTLE=1 instance, checked end to end.
    task automatic run_op(input string tag, input vec_t v);
        int lat;
        @(posedge clk); #1;
        if (v.id) begin
            req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_sub = v.sub;
        end else begin
            req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_sub = v.sub;
        end
        @(negedge clk);
        chk({tag, " grant"}, {req1_ready, req0_ready}, v.id ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        chk({tag, " ready pulse"}, {req1_ready, req0_ready}, 2'b00);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, 1);
        chk({tag, " id"},      rsp_id,   v.id);
        chk({tag, " sum"},     rsp_sum,  v.sum);
        chk({tag, " cout"},    rsp_cout, v.cout);
        chk({tag, " ovf"},     rsp_ovf,  v.ovf);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, " valid drop"}, rsp_valid, 0);
        chk({tag, " sum held"},   rsp_sum,   v.sum);
    endtask

    // Wait for a response on the SETTLE=1 instance and acknowledge it.
    task automatic wait_ack(input string tag, input logic [3:0] exp_sum);
        int lat;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " seen"}, rsp_valid, 1);
        chk({tag, " sum"},  rsp_sum,   exp_sum);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ng, nr, lat, seen;

        vecs[0] = '{1'b0, 4'd5, 4'd1, 1'b0, 4'd6,  1'b0, 1'b0};
        vecs[1] = '{1'b1, 4'd5, 4'd1, 1'b1, 4'd4,  1'b1, 1'b0};
        vecs[2] = '{1'b1, 4'd2, 4'd2, 1'b1, 4'd0,  1'b1, 1'b0};
        vecs[3] = '{1'b1, 4'd1, 4'd5, 1'b1, 4'd12, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 4'd0, 4'd0, 1'b1, 4'd0,  1'b1, 1'b0};
        vecs[5] = '{1'b0, 4'd7, 4'd1, 1'b0, 4'd8,  1'b0, 1'b1};
        vecs[6] = '{1'b0, 4'd8, 4'd1, 1'b1, 4'd7,  1'b1, 1'b1};
        vecs[7] = '{1'b0, 4'd2, 4'd2, 1'b0, 4'd4,  1'b0, 1'b0};
        vecs[8] = '{1'b0, 4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 4'd8, 4'd8, 1'b0, 4'd0,  1'b1, 1'b1};

        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        rst_4 = 1'b1; rsp_ready_4 = 1'b0;
        req0_valid_4 = 1'b0; req0_a_4 = '0; req0_b_4 = '0; req0_sub_4 = 1'b0;
        req1_valid_4 = 1'b0; req1_a_4 = '0; req1_b_4 = '0; req1_sub_4 = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_id",    rsp_id,    0);
        chk("reset rsp_sum",   rsp_sum,   0);
        chk("reset rsp_cout",  rsp_cout,  0);
        chk("reset rsp_ovf",   rsp_ovf,   0);
        chk("reset readies",   {req1_ready, req0_ready}, 2'b00);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Round-robin with both requesters continuously valid after reset.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd3; req1_sub = 1'b0;
        rsp_ready = 1'b1;
        ng = 0;
        nr = 0;
        for (int c = 0; c < 40 && nr < 4; c++) begin
            @(negedge clk);
            if ((req0_ready || req1_ready) && ng < 4) begin
                chk($sformatf("rr grant%0d", ng), {req1_ready, req0_ready},
                    (ng % 2) ? 2'b10 : 2'b01);
                ng++;
            end
            if (rsp_valid) begin
                chk($sformatf("rr rsp_id%0d", nr),  rsp_id,  nr % 2);
                chk($sformatf("rr rsp_sum%0d", nr), rsp_sum, (nr % 2) ? 6 : 2);
                nr++;
            end
            @(posedge clk); #1;
            if (ng >= 4) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        rsp_ready = 1'b0;
        chk("rr grant count",    ng, 4);
        chk("rr response count", nr, 4);
`ifdef ADDSUB_ARB_STATS_EN
        chk("rr stat_cnt0", stat_cnt0, 2);
        chk("rr stat_cnt1", stat_cnt1, 2);
`endif

        // Backpressure: response held for 3 cycles with both requesters waiting.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd4; req0_sub = 1'b0;
        @(negedge clk);
        chk("bp grant", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd9; req1_sub = 1'b1;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp valid%0d", k),   rsp_valid, 1);
            chk($sformatf("bp id%0d", k),      rsp_id,    0);
            chk($sformatf("bp sum%0d", k),     rsp_sum,   7);
            chk($sformatf("bp cout%0d", k),    rsp_cout,  0);
            chk($sformatf("bp ovf%0d", k),     rsp_ovf,   0);
            chk($sformatf("bp readies%0d", k), {req1_ready, req0_ready}, 2'b00);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp valid drop", rsp_valid, 0);
        @(negedge clk);
        chk("bp next grant", {req1_ready, req0_ready}, 2'b10);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_ack("bp req1", 4'd0);

        // SETTLE=4: complete one op, then abort a second one with reset.
        @(posedge clk); #1;
        rst_4 = 1'b0;
        req1_valid_4 = 1'b1; req1_a_4 = 4'd9; req1_b_4 = 4'd3; req1_sub_4 = 1'b0;
        @(negedge clk);
        chk("s4 grant1", {req1_ready_4, req0_ready_4}, 2'b10);
        @(posedge clk); #1;
        req1_valid_4 = 1'b0;
        lat = 0;
        while (!rsp_valid_4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("s4 latency", lat, 4);
        chk("s4 id",   rsp_id_4,   1);
        chk("s4 sum",  rsp_sum_4,  12);
        chk("s4 cout", rsp_cout_4, 0);
        chk("s4 ovf",  rsp_ovf_4,  0);
        rsp_ready_4 = 1'b1;
        @(posedge clk); #1;
        rsp_ready_4 = 1'b0;

        req0_valid_4 = 1'b1; req0_a_4 = 4'd6; req0_b_4 = 4'd7; req0_sub_4 = 1'b0;
        req1_valid_4 = 1'b1; req1_a_4 = 4'd1; req1_b_4 = 4'd1; req1_sub_4 = 1'b0;
        @(negedge clk);
        chk("s4 tie grant", {req1_ready_4, req0_ready_4}, 2'b01);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_4 = 1'b1;
        req0_valid_4 = 1'b0;
        req1_valid_4 = 1'b0;
        @(posedge clk); #1;
        rst_4 = 1'b0;
        chk("abort rsp_valid", rsp_valid_4, 0);
        chk("abort rsp_id",    rsp_id_4,    0);
        chk("abort rsp_sum",   rsp_sum_4,   0);
        chk("abort rsp_cout",  rsp_cout_4,  0);
        chk("abort rsp_ovf",   rsp_ovf_4,   0);
        chk("abort readies",   {req1_ready_4, req0_ready_4}, 2'b00);
`ifdef ADDSUB_ARB_STATS_EN
        chk("abort stat_cnt0", stat_cnt0_4, 0);
        chk("abort stat_cnt1", stat_cnt1_4, 0);
`endif
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid_4) seen = 1;
        end
        chk("abort no response", seen, 0);

        @(posedge clk); #1;
        req0_valid_4 = 1'b1;
        req1_valid_4 = 1'b1;
        @(negedge clk);
        chk("abort next tie", {req1_ready_4, req0_ready_4}, 2'b01);
        @(posedge clk); #1;
        req0_valid_4 = 1'b0;
        req1_valid_4 = 1'b0;
        lat = 0;
        while (!rsp_valid_4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("post-abort latency", lat, 4);
        chk("post-abort id",   rsp_id_4,   0);
        chk("post-abort sum",  rsp_sum_4,  13);
        chk("post-abort cout", rsp_cout_4, 0);
        chk("post-abort ovf",  rsp_ovf_4,  1);
        rsp_ready_4 = 1'b1;
        @(posedge clk); #1;
        rsp_ready_4 = 1'b0;
        chk("post-abort valid drop", rsp_valid_4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
